sd_block_buffer: RTL and testbench

Single-block write-back buffer between a 32-bit word requester (CPU/bus side) and the SD controller's 4096-bit block port (`rd_en`/`wr_en`/`addr`/`write_data`/`read_data`/`busy`). It holds one 512-byte block with a tag, valid and dirty bit. It serves word reads and writes from that block. On a miss it writes back the dirty block (if any), then fills the new block from the controller. It also provides an explicit flush.

---
 rtl/sd_block_buffer_if.sv | 46 ++++
 rtl/sd_block_buffer.sv | 172 +++++++++++++++++
 tb/tb_sd_block_buffer.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_buffer_if.sv
// -----------------------------------------------------------------------------
// sd_block_buffer_if
//   Signal bundle for sd_block_buffer. It carries two groups of signals.
//   Word side (requester):
//     word_rd_en, word_wr_en   word read/write requests, held until word_ack
//     word_addr, word_wr_data  byte address and write data
//     word_byte_en             byte enables for writes
//     word_rd_data, word_ack   registered read data and completion pulse
//     flush, flush_done        write-back request and completion pulse
//   Block side (SD controller):
//     rd_en, wr_en, addr       block read/write request and block index
//     write_data, read_data    4096-bit block data out/in
//     busy                     controller busy flag
//   Modports:
//     slave  - the buffer's view
//     master - the requester/controller environment's view
// -----------------------------------------------------------------------------
interface sd_block_buffer_if;
  logic          word_rd_en;
  logic          word_wr_en;
  logic [31:0]   word_addr;
  logic [31:0]   word_wr_data;
  logic [3:0]    word_byte_en;
  logic [31:0]   word_rd_data;
  logic          word_ack;
  logic          flush;
  logic          flush_done;
  logic          rd_en;
  logic          wr_en;
  logic [31:0]   addr;
  logic [4095:0] write_data;
  logic [4095:0] read_data;
  logic          busy;

  modport slave (
    input  word_rd_en, word_wr_en, word_addr, word_wr_data, word_byte_en,
    input  flush, read_data, busy,
    output word_rd_data, word_ack, flush_done, rd_en, wr_en, addr, write_data
  );

  modport master (
    output word_rd_en, word_wr_en, word_addr, word_wr_data, word_byte_en,
    output flush, read_data, busy,
    input  word_rd_data, word_ack, flush_done, rd_en, wr_en, addr, write_data
  );
endinterface

// File: rtl/sd_block_buffer.sv
// -----------------------------------------------------------------------------
// sd_block_buffer
//   Single-block write-back buffer between a 32-bit word requester and the SD
//   controller's 4096-bit block port. Holds one 512-byte block plus tag, valid
//   and dirty bits. Word hits are served from the buffer; a miss writes back
//   the dirty block (if any) and then fills the requested block. An explicit
//   flush writes back a dirty block without refilling.
//   Ports:
//     clock      system clock, rising edge
//     reset      asynchronous active-low reset
//     bus        sd_block_buffer_if.slave (word side + controller side)
//     dbg_state  current FSM state code
// -----------------------------------------------------------------------------
module sd_block_buffer (
  input  logic                  clock,
  input  logic                  reset,
  sd_block_buffer_if.slave      bus,
  output logic [15:0]           dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACK       = 3'd1,
    ST_WB_REQ    = 3'd2,
    ST_WB_WAIT   = 3'd3,
    ST_RD_REQ    = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_FLUSH_ACK = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [4095:0] blk_q, blk_d;
  logic [22:0]   tag_q, tag_d;
  logic          valid_q, valid_d;
  logic          dirty_q, dirty_d;
  logic          flush_q, flush_d;   // write-back was started by a flush
  logic [31:0]   rd_data_q, rd_data_d;

  logic [22:0]   req_blk;
  logic [6:0]    req_word;
  logic [11:0]   word_base;
  logic          hit;
  logic [31:0]   cur_word;
  logic [31:0]   merged_word;
  logic          unused_addr_bits;

  assign req_blk          = bus.word_addr[31:9];
  assign req_word         = bus.word_addr[8:2];
  assign word_base        = {req_word, 5'b00000};
  assign hit              = valid_q && (tag_q == req_blk);
  assign cur_word         = blk_q[word_base +: 32];
  assign unused_addr_bits = ^bus.word_addr[1:0];

  // Byte-lane merge of write data into the currently buffered word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_merge
    assign merged_word[8*gi +: 8] = bus.word_byte_en[gi] ? bus.word_wr_data[8*gi +: 8]
                                                         : cur_word[8*gi +: 8];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      blk_q     <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      dirty_q   <= 1'b0;
      flush_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      flush_q   <= flush_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    flush_d   = flush_q;
    rd_data_d = rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.word_wr_en || bus.word_rd_en) begin
          if (hit) begin
            // Write wins when both requests are raised together.
            if (bus.word_wr_en) begin
              blk_d[word_base +: 32] = merged_word;
              dirty_d                = 1'b1;
            end else begin
              rd_data_d = cur_word;
            end
            state_d = ST_ACK;
          end else if (valid_q && dirty_q) begin
            state_d = ST_WB_REQ;
          end else begin
            state_d = ST_RD_REQ;
          end
        end else if (bus.flush) begin
          if (dirty_q) begin
            flush_d = 1'b1;
            state_d = ST_WB_REQ;
          end else begin
            state_d = ST_FLUSH_ACK;
          end
        end
      end

      ST_ACK: state_d = ST_IDLE;

      ST_WB_REQ: begin
        if (bus.busy) state_d = ST_WB_WAIT;
      end

      ST_WB_WAIT: begin
        if (!bus.busy) begin
          dirty_d = 1'b0;
          state_d = flush_q ? ST_FLUSH_ACK : ST_RD_REQ;
        end
      end

      ST_RD_REQ: begin
        if (bus.busy) state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        // The requester still holds word_addr, so it names the block being filled.
        if (!bus.busy) begin
          blk_d   = bus.read_data;
          tag_d   = req_blk;
          valid_d = 1'b1;
          dirty_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_FLUSH_ACK: begin
        flush_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Enables and pulses decode straight from the state register, so an
  // asynchronous reset drops them immediately.
  always_comb begin
    bus.addr = '0;
    if (state_q == ST_WB_REQ) begin
      bus.addr = {9'b0, tag_q};
    end else if (state_q == ST_RD_REQ) begin
      bus.addr = {9'b0, req_blk};
    end
  end

  assign bus.wr_en        = (state_q == ST_WB_REQ);
  assign bus.rd_en        = (state_q == ST_RD_REQ);
  assign bus.word_ack     = (state_q == ST_ACK);
  assign bus.flush_done   = (state_q == ST_FLUSH_ACK);
  assign bus.word_rd_data = rd_data_q;
  assign bus.write_data   = blk_q;
  assign dbg_state        = {13'b0, state_q};

endmodule

// File: tb/tb_sd_block_buffer.sv
// -----------------------------------------------------------------------------
// tb_sd_block_buffer
//   Directed scenarios followed by randomized word reads/writes/flushes. The
//   reference model is a word-addressed memory (shadow = what the requester
//   should see, committed = what has reached the SD device) plus a record of
//   which block the buffer should be holding and whether it is dirty.
// -----------------------------------------------------------------------------
module tb_sd_block_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dbg_state;

  sd_block_buffer_if bus_if ();

  sd_block_buffer u_dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- background content ----------------
  function automatic logic [31:0] pat(input logic [29:0] wa);
    return {wa[15:0], ~wa[15:0]} ^ 32'hA5C3_0F1E;
  endfunction

  // ---------------- SD controller environment ----------------
  logic [4095:0] dev_mem [logic [22:0]];
  logic [31:0]   obs_wr_addr_q [$];
  logic [4095:0] obs_wr_data_q [$];
  logic [31:0]   obs_rd_addr_q [$];
  bit            ctrl_quick = 1'b0;

  function automatic logic [4095:0] dev_block(input logic [22:0] b);
    logic [4095:0] v;
    if (dev_mem.exists(b)) return dev_mem[b];
    for (int w = 0; w < 128; w++) v[w*32 +: 32] = pat({b, w[6:0]});
    return v;
  endfunction

  initial begin
    bus_if.busy      = 1'b0;
    bus_if.read_data = '0;
    forever begin
      @(negedge clock);
      if (reset && (bus_if.rd_en || bus_if.wr_en)) begin
        int dly;
        int hold;
        if (bus_if.wr_en) begin
          obs_wr_addr_q.push_back(bus_if.addr);
          obs_wr_data_q.push_back(bus_if.write_data);
          dev_mem[bus_if.addr[22:0]] = bus_if.write_data;
        end else begin
          obs_rd_addr_q.push_back(bus_if.addr);
          bus_if.read_data = dev_block(bus_if.addr[22:0]);
        end
        dly  = ctrl_quick ? 0 : $urandom_range(0, 2);
        hold = $urandom_range(1, 3);
        repeat (dly) @(negedge clock);
        bus_if.busy = 1'b1;
        repeat (hold) @(negedge clock);
        bus_if.busy = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] shadow    [logic [29:0]];
  logic [31:0] committed [logic [29:0]];
  bit          m_valid = 1'b0;
  bit          m_dirty = 1'b0;
  logic [22:0] m_tag   = '0;

  function automatic logic [31:0] shadow_rd(input logic [29:0] wa);
    return shadow.exists(wa) ? shadow[wa] : pat(wa);
  endfunction

  function automatic logic [31:0] committed_rd(input logic [29:0] wa);
    return committed.exists(wa) ? committed[wa] : pat(wa);
  endfunction

  function automatic logic [4095:0] shadow_block(input logic [22:0] b);
    logic [4095:0] v;
    for (int w = 0; w < 128; w++) v[w*32 +: 32] = shadow_rd({b, w[6:0]});
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic model_commit(input logic [22:0] b);
    for (int w = 0; w < 128; w++) committed[{b, w[6:0]}] = shadow_rd({b, w[6:0]});
  endtask

  // A reset discards uncommitted writes held in the buffer.
  task automatic model_reset();
    if (m_valid)
      for (int w = 0; w < 128; w++) shadow[{m_tag, w[6:0]}] = committed_rd({m_tag, w[6:0]});
    m_valid = 1'b0;
    m_dirty = 1'b0;
  endtask

  task automatic preload_word(input logic [31:0] a, input logic [31:0] val);
    logic [4095:0] blk;
    blk = dev_block(a[31:9]);
    blk[int'(a[8:2])*32 +: 32] = val;
    dev_mem[a[31:9]] = blk;
    committed[a[31:2]] = val;
    shadow[a[31:2]]    = val;
  endtask

  task automatic check_wb_data(input string tag, input logic [4095:0] got, input logic [4095:0] exp);
    int mw;
    mw = 0;
    for (int w = 127; w >= 0; w--) if (got[w*32 +: 32] !== exp[w*32 +: 32]) mw = w;
    check_val(tag, got[mw*32 +: 32], exp[mw*32 +: 32]);
  endtask

  // ---------------- transactions (called just after a negedge) ----------------
  task automatic do_op(input bit is_wr, input bit both, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       output logic [31:0] got_rd, output logic [4095:0] got_wb);
    logic [22:0]   b;
    logic [29:0]   wa;
    bit            hit, exp_wb, got_ack;
    logic [22:0]   exp_wb_tag;
    logic [4095:0] exp_wb_data;
    logic [31:0]   exp_rd;
    int            cycles;

    b           = a[31:9];
    wa          = a[31:2];
    hit         = m_valid && (m_tag == b);
    exp_wb      = !hit && m_valid && m_dirty;
    exp_wb_tag  = m_tag;
    exp_wb_data = shadow_block(m_tag);
    exp_rd      = '0;
    if (!hit) begin
      if (exp_wb) model_commit(m_tag);
      m_valid = 1'b1;
      m_tag   = b;
      m_dirty = 1'b0;
    end
    if (is_wr) begin
      shadow[wa] = merge(shadow_rd(wa), d, be);
      m_dirty    = 1'b1;
    end else begin
      exp_rd = shadow_rd(wa);
    end

    obs_wr_addr_q.delete();
    obs_wr_data_q.delete();
    obs_rd_addr_q.delete();

    bus_if.word_wr_en   = is_wr;
    bus_if.word_rd_en   = !is_wr || both;
    bus_if.word_addr    = a;
    bus_if.word_wr_data = d;
    bus_if.word_byte_en = be;

    cycles  = 0;
    got_ack = 1'b0;
    while (cycles < 200 && !got_ack) begin
      @(negedge clock);
      cycles++;
      got_ack = bus_if.word_ack;
    end
    got_rd = bus_if.word_rd_data;
    bus_if.word_wr_en = 1'b0;
    bus_if.word_rd_en = 1'b0;

    check_val("ack_seen", got_ack, 1);
    if (!is_wr) check_val("rd_data", got_rd, exp_rd);
    if (hit) check_val("hit_latency", cycles, 1);
    else     check_val("miss_latency_ge4", cycles >= 4, 1);
    check_val("wb_count", obs_wr_addr_q.size(), exp_wb);
    check_val("fill_count", obs_rd_addr_q.size(), !hit);
    got_wb = '0;
    if (exp_wb && obs_wr_addr_q.size() == 1) begin
      check_val("wb_addr", obs_wr_addr_q[0], {9'b0, exp_wb_tag});
      check_wb_data("wb_data", obs_wr_data_q[0], exp_wb_data);
      got_wb = obs_wr_data_q[0];
    end
    if (!hit && obs_rd_addr_q.size() == 1) check_val("fill_addr", obs_rd_addr_q[0], {9'b0, b});

    @(negedge clock);
    check_val("ack_pulse", bus_if.word_ack, 0);
    check_val("addr_idle", bus_if.addr, 0);
    $display("op=%s addr=0x%08h data=0x%08h be=%b hit=%0d wb=%0d cycles=%0d",
             is_wr ? "WR" : "RD", a, is_wr ? d : got_rd, be, hit, exp_wb, cycles);
  endtask

  task automatic do_flush(output logic [4095:0] got_wb);
    bit            exp_wb, got_done;
    logic [22:0]   exp_tag;
    logic [4095:0] exp_data;
    int            cycles;

    exp_wb   = m_valid && m_dirty;
    exp_tag  = m_tag;
    exp_data = shadow_block(m_tag);
    if (exp_wb) model_commit(m_tag);
    m_dirty = 1'b0;

    obs_wr_addr_q.delete();
    obs_wr_data_q.delete();
    obs_rd_addr_q.delete();

    bus_if.flush = 1'b1;
    cycles   = 0;
    got_done = 1'b0;
    while (cycles < 200 && !got_done) begin
      @(negedge clock);
      cycles++;
      got_done = bus_if.flush_done;
    end
    bus_if.flush = 1'b0;

    check_val("flush_done_seen", got_done, 1);
    if (exp_wb) check_val("flush_latency_ge3", cycles >= 3, 1);
    else        check_val("flush_latency", cycles, 1);
    check_val("flush_wb_count", obs_wr_addr_q.size(), exp_wb);
    check_val("flush_fill_count", obs_rd_addr_q.size(), 0);
    got_wb = '0;
    if (exp_wb && obs_wr_addr_q.size() == 1) begin
      check_val("flush_wb_addr", obs_wr_addr_q[0], {9'b0, exp_tag});
      check_wb_data("flush_wb_data", obs_wr_data_q[0], exp_data);
      got_wb = obs_wr_data_q[0];
    end

    @(negedge clock);
    check_val("flush_done_pulse", bus_if.flush_done, 0);
    $display("op=FLUSH dirty=%0d cycles=%0d", exp_wb, cycles);
  endtask

  // ---------------- main sequence ----------------
  logic [22:0]   blks [4];
  logic [31:0]   rdv;
  logic [4095:0] wbv;

  initial begin
    bus_if.word_rd_en   = 1'b0;
    bus_if.word_wr_en   = 1'b0;
    bus_if.word_addr    = '0;
    bus_if.word_wr_data = '0;
    bus_if.word_byte_en = '0;
    bus_if.flush        = 1'b0;
    blks[0] = 23'h20;
    blks[1] = 23'h40;
    blks[2] = 23'h0;
    blks[3] = 23'h7FFFFF;

    // Reset held with random requester inputs.
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      bus_if.word_rd_en   = 1'($urandom);
      bus_if.word_wr_en   = 1'($urandom);
      bus_if.word_addr    = $urandom;
      bus_if.word_wr_data = $urandom;
      bus_if.word_byte_en = 4'($urandom);
      bus_if.flush        = 1'($urandom);
      #1;
      check_val("rst_rd_en", bus_if.rd_en, 0);
      check_val("rst_wr_en", bus_if.wr_en, 0);
      check_val("rst_addr", bus_if.addr, 0);
      check_val("rst_ack", bus_if.word_ack, 0);
      check_val("rst_flush_done", bus_if.flush_done, 0);
      check_val("rst_rd_data", bus_if.word_rd_data, 0);
      check_val("rst_wdata_any", |bus_if.write_data, 0);
      check_val("rst_state", dbg_state, 0);
      $display("reset cycle %0d checked", i);
    end
    @(negedge clock);
    bus_if.word_rd_en = 1'b0;
    bus_if.word_wr_en = 1'b0;
    bus_if.flush      = 1'b0;
    reset = 1'b1;

    // Cold read miss returning the preloaded word.
    preload_word(32'h0000_4004, 32'hDEADBEEF);
    do_op(1'b0, 1'b0, 32'h0000_4004, 32'h0, 4'h0, rdv, wbv);
    check_val("cold_rd_data", rdv, 32'hDEADBEEF);

    // Partial write hit, then read back.
    do_op(1'b1, 1'b0, 32'h0000_4004, 32'h1234_5678, 4'b0011, rdv, wbv);
    do_op(1'b0, 1'b0, 32'h0000_4004, 32'h0, 4'h0, rdv, wbv);
    check_val("merged_rd_data", rdv, 32'hDEAD5678);

    // Dirty miss: write-back of block 0x20 then fill of block 0x40.
    do_op(1'b0, 1'b0, 32'h0000_8000, 32'h0, 4'h0, rdv, wbv);
    check_val("dirty_wb_word1", wbv[63:32], 32'hDEAD5678);

    // Flush on clean buffer, then after a write hit.
    do_flush(wbv);
    do_op(1'b1, 1'b1, 32'h0000_8010, 32'hCAFE_F00D, 4'b1111, rdv, wbv);
    do_flush(wbv);
    check_val("flush_wb_word4", wbv[159:128], 32'hCAFE_F00D);
    do_op(1'b0, 1'b0, 32'h0000_4004, 32'h0, 4'h0, rdv, wbv);

    // Reset while the controller is busy with a fill request.
    ctrl_quick = 1'b1;
    obs_rd_addr_q.delete();
    bus_if.word_rd_en = 1'b1;
    bus_if.word_addr  = 32'h0000_C000;
    begin
      int n;
      n = 0;
      while (n < 50 && !(bus_if.rd_en && bus_if.busy)) begin
        @(negedge clock);
        #2;
        n++;
      end
      check_val("midrst_rd_en_seen", bus_if.rd_en && bus_if.busy, 1);
    end
    reset = 1'b0;
    #1;
    check_val("midrst_rd_en_drop", bus_if.rd_en, 0);
    check_val("midrst_state", dbg_state, 0);
    check_val("midrst_addr", bus_if.addr, 0);
    bus_if.word_rd_en = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    ctrl_quick = 1'b0;
    begin
      int n;
      n = 0;
      while (n < 20 && bus_if.busy) begin
        @(negedge clock);
        n++;
      end
      check_val("midrst_busy_clear", bus_if.busy, 0);
    end
    $display("reset during fill request checked");
    do_op(1'b0, 1'b0, 32'h0000_4004, 32'h0, 4'h0, rdv, wbv);

    // Randomized traffic over a handful of blocks.
    for (int i = 0; i < 70; i++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      a = {blks[$urandom_range(0, 3)], 7'($urandom), 2'($urandom)};
      if (r < 15)      do_flush(wbv);
      else if (r < 55) do_op(1'b1, $urandom_range(0, 9) == 0, a, $urandom, 4'($urandom), rdv, wbv);
      else             do_op(1'b0, 1'b0, a, 32'h0, 4'h0, rdv, wbv);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
